// File: rtl/divu_seq_pkg.sv
// Shared definitions for the sequential unsigned divider: DIVU funct code and FSM encodings.
package divu_seq_pkg;

    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divu_seq_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R_next,
    output logic [WIDTH-1:0] Q_next
);

    logic [WIDTH:0] trial;

    // Shift in the next dividend bit and try subtracting; a borrow means restore.
    always_comb begin
        trial = {R, Q[WIDTH-1]} - {1'b0, D};
        if (trial[WIDTH] == 1'b0) begin
            R_next = trial[WIDTH-1:0];
            Q_next = {Q[WIDTH-2:0], 1'b1};
        end else begin
            R_next = {R[WIDTH-2:0], Q[WIDTH-1]};
            Q_next = {Q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned divider: one quotient bit per clock, result as {remainder, quotient}.
module divu_seq
    import divu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   DivAns
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .R      (rem_reg),
        .Q      (quo_reg),
        .D      (div_reg),
        .R_next (rem_next),
        .Q_next (quo_next)
    );

    // A start is accepted from IDLE and from DONE, so results can stream back-to-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            rem_reg  <= '0;
            quo_reg  <= '0;
            div_reg  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            DivAns   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE, DIV_DONE: begin
                    if (start) begin
                        if (dataB == '0) begin
                            state    <= DIV_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            DivAns   <= {dataA, {WIDTH{1'b1}}};
                        end else begin
                            state    <= DIV_CALC;
                            busy     <= 1'b1;
                            div_zero <= 1'b0;
                            cnt      <= '0;
                            rem_reg  <= '0;
                            quo_reg  <= dataA;
                            div_reg  <= dataB;
                        end
                    end else begin
                        state <= DIV_IDLE;
                        busy  <= 1'b0;
                    end
                end
                DIV_CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state  <= DIV_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        DivAns <= {rem_next, quo_next};
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
// Directed and random checks of divu_seq against a/b, a%b with a result scoreboard.
module tb_divu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [63:0] DivAns;

    int errors = 0;
    int checks = 0;
    logic [64:0] sb_q[$];
    logic [64:0] mon_exp;

    divu_seq #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dataA    (dataA),
        .dataB    (dataB),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .DivAns   (DivAns)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input bit expect_result);
        start = 1'b1;
        dataA = a;
        dataB = b;
        if (expect_result)
            sb_q.push_back((b == 32'd0) ? {1'b1, a, 32'hFFFF_FFFF} : {1'b0, a % b, a / b});
        tick();
        start = 1'b0;
        dataA = $urandom;
        dataB = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, output int busy_cnt);
        int k = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            k++;
        end
        check_output({tag, "_latency"}, 65'(k), 65'(exp_lat));
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_output("spurious_done", 65'(done), 65'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check_output("result", {div_zero, DivAns}, mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int bc;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1'b1;
        start = 1'b0;
        dataA = '0;
        dataB = '0;
        repeat (3) tick();
        check_output("reset_busy", 65'(busy), 65'd0);
        check_output("reset_done", 65'(done), 65'd0);
        check_output("reset_out", {div_zero, DivAns}, 65'd0);
        reset = 1'b0;
        tick();

        apply_stimulus(32'd100, 32'd7, 1'b1);
        wait_done("d100_7", 32, bc);
        check_output("d100_7_busy_cycles", 65'(bc), 65'd32);
        check_output("d100_7_busy_at_done", 65'(busy), 65'd0);
        tick();
        check_output("done_one_cycle", 65'(done), 65'd0);
        check_output("result_held", {div_zero, DivAns}, {1'b0, 32'd2, 32'd14});

        apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done("dmax_1", 32, bc);
        tick();
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("dmax_max", 32, bc);
        tick();
        apply_stimulus(32'd3, 32'd10, 1'b1);
        wait_done("d3_10", 32, bc);
        tick();
        apply_stimulus(32'd0, 32'd5, 1'b1);
        wait_done("d0_5", 32, bc);
        tick();

        apply_stimulus(32'd5, 32'd0, 1'b1);
        wait_done("d5_0", 0, bc);
        check_output("d5_0_busy_cycles", 65'(bc), 65'd0);
        check_output("d5_0_busy", 65'(busy), 65'd0);
        tick();
        check_output("div_zero_held", {div_zero, DivAns}, {1'b1, 32'd5, 32'hFFFF_FFFF});
        apply_stimulus(32'd9, 32'd3, 1'b1);
        check_output("div_zero_cleared", 65'(div_zero), 65'd0);
        wait_done("d9_3", 32, bc);
        tick();

        apply_stimulus(32'd1000, 32'd3, 1'b1);
        repeat (4) tick();
        start = 1'b1;
        dataA = 32'd8;
        dataB = 32'd2;
        tick();
        start = 1'b0;
        wait_done("ignore_start", 27, bc);
        tick();

        apply_stimulus(32'd1000, 32'd3, 1'b0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("abort_busy", 65'(busy), 65'd0);
        check_output("abort_done", 65'(done), 65'd0);
        check_output("abort_out", {div_zero, DivAns}, 65'd0);
        repeat (40) tick();
        apply_stimulus(32'd50, 32'd7, 1'b1);
        wait_done("d50_7", 32, bc);
        tick();

        reset = 1'b1;
        start = 1'b1;
        dataA = 32'd20;
        dataB = 32'd3;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_output("reset_wins_busy", 65'(busy), 65'd0);
        tick();
        check_output("reset_wins_idle", {busy, done}, 65'd0);

        apply_stimulus(32'd17, 32'd4, 1'b1);
        wait_done("b2b_first", 32, bc);
        apply_stimulus(32'd81, 32'd9, 1'b1);
        wait_done("b2b_second", 32, bc);
        tick();

        for (int i = 0; i < 300; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if (i % 17 == 0) b = 32'd0;
            apply_stimulus(a, b, 1'b1);
            wait_done("rand", (b == 32'd0) ? 0 : 32, bc);
            tick();
        end

        tick();
        check_output("sb_drained", 65'(sb_q.size()), 65'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
